// File: rtl/bin2bcd_disp_if.sv
// bin2bcd_disp_if
// Groups the conversion request and the display result of bin2bcd_disp.
//   bin_in   : unsigned binary value to convert (requester -> converter)
//   start    : conversion request, level-sampled (requester -> converter)
//   busy     : conversion in progress (converter -> requester)
//   done     : one-cycle completion pulse (converter -> requester)
//   ovf      : last accepted value did not fit in DIGITS digits
//   data_out : packed BCD display word, MSD in the top nibble
// Modports: master = requester / display side, slave = the converter.
interface bin2bcd_disp_if #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
);
  logic [BIN_W-1:0]    bin_in;
  logic                start;
  logic                busy;
  logic                done;
  logic                ovf;
  logic [4*DIGITS-1:0] data_out;

  modport master (
    output bin_in,
    output start,
    input  busy,
    input  done,
    input  ovf,
    input  data_out
  );

  modport slave (
    input  bin_in,
    input  start,
    output busy,
    output done,
    output ovf,
    output data_out
  );
endinterface

// File: rtl/bin2bcd_disp.sv
// bin2bcd_disp
// Sequential double-dabble binary-to-BCD converter feeding the six-digit
// seven-segment driver. One shift-and-add-3 step per clk_1khz cycle; the
// previous display word stays on data_out until the new one is complete.
// Values above 10^DIGITS-1 display as all 'E' digits and raise ovf.
// Ports:
//   clk_1khz : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : bin2bcd_disp_if slave (bin_in, start, busy, done, ovf, data_out)
module bin2bcd_disp #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic           clk_1khz,
  input  logic           rst_n,
  bin2bcd_disp_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(10**DIGITS - 1);
  localparam logic [BCD_W-1:0] ERR_WORD = {DIGITS{4'hE}};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [BCD_W-1:0] data_q, data_d;

  // Pre-shift correction: any digit >= 5 would become >= 10 after doubling,
  // so add 3 first to make it carry into the next digit instead.
  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Saturate an out-of-range result to the all-'E' error word.
  function automatic logic [BCD_W-1:0] display_word(input logic [BCD_W-1:0] b,
                                                    input logic            over);
    return over ? ERR_WORD : b;
  endfunction

  assign bcd_adj = add3_adjust(bcd_q);

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    data_d     = data_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d      = bus.bin_in;
          bcd_d      = '0;
          cnt_d      = CNT_LOAD;
          ovf_pend_d = (bus.bin_in > MAX_VAL);
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q - CNT_ONE;
        // Counter holds 1 here on the last step; it reaches 0 on this edge.
        if (cnt_q == CNT_ONE) state_d = DONE;
      end
      DONE: begin
        data_d  = display_word(bcd_q, ovf_pend_q);
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ovf      = ovf_q;
  assign bus.data_out = data_q;

endmodule

// File: tb/tb_bin2bcd_disp.sv
// tb_bin2bcd_disp
// Self-checking bench for bin2bcd_disp: randomized and directed conversions
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_disp;

  logic clk_1khz;
  logic rst_n;
  int   checks;
  int   failures;
  logic [23:0] last_exp;

  bin2bcd_disp_if #(.BIN_W(20), .DIGITS(6)) bus ();

  bin2bcd_disp #(.BIN_W(20), .DIGITS(6)) dut (
    .clk_1khz (clk_1khz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial clk_1khz = 1'b0;
  always #5 clk_1khz = ~clk_1khz;

  // Reference: decimal digits by division, all-E for values above 999999.
  function automatic logic [23:0] ref_disp(input int unsigned v);
    logic [23:0] r;
    int unsigned p;
    r = '0;
    if (v > 999999) return 24'hEEEEEE;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Runs one conversion and observes it for 45 cycles. bin_in is scrambled
  // while busy; if glitch_k > 0 a start with 111111 is presented at edge E<glitch_k>.
  task automatic drive_conv(input logic [19:0] val, input int glitch_k,
                            input logic [23:0] prev_exp,
                            output int lat, output logic [23:0] dout,
                            output logic o, output int busy_cycles,
                            output int done_cnt, output logic held_ok);
    lat = -1; dout = 'x; o = 1'bx; busy_cycles = 0; done_cnt = 0; held_ok = 1'b1;
    @(negedge clk_1khz);
    bus.bin_in = val;
    bus.start  = 1'b1;
    @(posedge clk_1khz);
    @(negedge clk_1khz);
    bus.start  = 1'b0;
    bus.bin_in = 20'($urandom);
    for (int k = 0; k < 45; k++) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (lat < 0) begin
          lat  = k;
          dout = bus.data_out;
          o    = bus.ovf;
        end
      end else if (lat < 0 && bus.data_out !== prev_exp) begin
        held_ok = 1'b0;
      end
      bus.start  = (glitch_k > 0 && k == glitch_k - 1);
      bus.bin_in = bus.start ? 20'd111111 : 20'($urandom);
      @(negedge clk_1khz);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(negedge clk_1khz);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
    checks++; if (bus.data_out !== 24'h000000) begin failures++; $display("FAIL reset_data got=%h exp=000000", bus.data_out); end
    rst_n = 1'b1;
    last_exp = 24'h000000;
    @(negedge clk_1khz);
  endtask

  task automatic test_basic();
    int lat, bc, dc; logic [23:0] d; logic o, held;
    drive_conv(20'd123456, 0, last_exp, lat, d, o, bc, dc, held);
    checks++; if (lat !== 21) begin failures++; $display("FAIL basic_latency got=%0d exp=21", lat); end
    checks++; if (d !== 24'h123456) begin failures++; $display("FAIL basic_data got=%h exp=123456", d); end
    checks++; if (o !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", o); end
    checks++; if (bc !== 21) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=21", bc); end
    checks++; if (dc !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", dc); end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL basic_held got=%b exp=1", held); end
    last_exp = 24'h123456;
  endtask

  task automatic test_in_range();
    int lat, bc, dc; logic [23:0] d, e; logic o, held;
    int unsigned fixed_v [3] = '{0, 999999, 1};
    int unsigned v;
    for (int i = 0; i < 11; i++) begin
      v = (i < 3) ? fixed_v[i] : $urandom_range(999999, 0);
      e = ref_disp(v);
      drive_conv(20'(v), 0, last_exp, lat, d, o, bc, dc, held);
      checks++; if (d !== e) begin failures++; $display("FAIL range_data v=%0d got=%h exp=%h", v, d, e); end
      checks++; if (o !== 1'b0) begin failures++; $display("FAIL range_ovf v=%0d got=%b exp=0", v, o); end
      checks++; if (lat !== 21) begin failures++; $display("FAIL range_latency v=%0d got=%0d exp=21", v, lat); end
      checks++; if (held !== 1'b1) begin failures++; $display("FAIL range_held v=%0d got=%b exp=1", v, held); end
      last_exp = e;
    end
  endtask

  task automatic test_overflow();
    int lat, bc, dc; logic [23:0] d, e; logic o, held;
    int unsigned v;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: v = 1000000;
        1: v = 20'hFFFFF;
        2: v = $urandom_range(1048575, 1000000);
        default: v = 5;
      endcase
      e = ref_disp(v);
      drive_conv(20'(v), 0, last_exp, lat, d, o, bc, dc, held);
      checks++; if (d !== e) begin failures++; $display("FAIL ovf_data v=%0d got=%h exp=%h", v, d, e); end
      checks++; if (o !== (v > 999999)) begin failures++; $display("FAIL ovf_flag v=%0d got=%b exp=%b", v, o, (v > 999999)); end
      last_exp = e;
    end
  endtask

  task automatic test_start_while_busy();
    int lat, bc, dc; logic [23:0] d; logic o, held;
    drive_conv(20'd654321, 10, last_exp, lat, d, o, bc, dc, held);
    checks++; if (d !== ref_disp(654321)) begin failures++; $display("FAIL busy_start_data got=%h exp=654321", d); end
    checks++; if (dc !== 1) begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", dc); end
    checks++; if (lat !== 21) begin failures++; $display("FAIL busy_start_latency got=%0d exp=21", lat); end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL busy_start_held got=%b exp=1", held); end
    checks++; if (bc !== 21) begin failures++; $display("FAIL busy_start_busy_cycles got=%0d exp=21", bc); end
    last_exp = 24'h654321;
  endtask

  task automatic test_back_to_back();
    int done_k [$];
    logic busy_after_done;
    busy_after_done = 1'b0;
    @(negedge clk_1khz);
    bus.bin_in = 20'd250;
    bus.start  = 1'b1;
    @(posedge clk_1khz);
    @(negedge clk_1khz);
    for (int k = 0; k < 95; k++) begin
      if (bus.done === 1'b1) begin
        done_k.push_back(k);
        checks++; if (bus.data_out !== ref_disp(250)) begin failures++; $display("FAIL b2b_data k=%0d got=%h exp=000250", k, bus.data_out); end
      end
      if (k == 22) busy_after_done = bus.busy;
      if (k == 70) bus.start = 1'b0;
      @(negedge clk_1khz);
    end
    checks++; if (done_k.size() !== 4) begin failures++; $display("FAIL b2b_done_count got=%0d exp=4", done_k.size()); end
    for (int n = 0; n < done_k.size() && n < 4; n++) begin
      checks++; if (done_k[n] !== 21 + 22 * n) begin failures++; $display("FAIL b2b_spacing n=%0d got=%0d exp=%0d", n, done_k[n], 21 + 22 * n); end
    end
    checks++; if (busy_after_done !== 1'b1) begin failures++; $display("FAIL b2b_no_gap got=%b exp=1", busy_after_done); end
    last_exp = ref_disp(250);
  endtask

  task automatic test_async_reset();
    int lat, bc, dc, spurious; logic [23:0] d; logic o, held;
    drive_conv(20'd777777, 0, last_exp, lat, d, o, bc, dc, held);
    checks++; if (d !== 24'h777777) begin failures++; $display("FAIL arst_pre_data got=%h exp=777777", d); end
    @(negedge clk_1khz);
    bus.bin_in = 20'd123;
    bus.start  = 1'b1;
    @(posedge clk_1khz);
    @(negedge clk_1khz);
    bus.start = 1'b0;
    repeat (7) @(negedge clk_1khz);
    @(posedge clk_1khz);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL arst_done got=%b exp=0", bus.done); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL arst_ovf got=%b exp=0", bus.ovf); end
    checks++; if (bus.data_out !== 24'h000000) begin failures++; $display("FAIL arst_data got=%h exp=000000", bus.data_out); end
    spurious = 0;
    repeat (3) begin
      @(negedge clk_1khz);
      if (bus.done === 1'b1) spurious++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk_1khz);
      if (bus.done === 1'b1) spurious++;
    end
    checks++; if (spurious !== 0) begin failures++; $display("FAIL arst_no_done got=%0d exp=0", spurious); end
    drive_conv(20'd42, 0, 24'h000000, lat, d, o, bc, dc, held);
    checks++; if (d !== ref_disp(42)) begin failures++; $display("FAIL arst_after_data got=%h exp=000042", d); end
    checks++; if (lat !== 21) begin failures++; $display("FAIL arst_after_latency got=%0d exp=21", lat); end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL arst_after_held got=%b exp=1", held); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_in_range();
    test_overflow();
    test_start_while_busy();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
